forward_ctrl: RTL and testbench
===============================

# forward_ctrl

Pipelined-CPU forwarding and load-use control block. It tracks the destination register, write-enable and load flag of every instruction in EX, MEM, WB and one retired slot. It produces the registered 2-bit select pairs that drive the ALU operand 4:1 multiplexers, and a combinational stall request for load-use hazards. It sits between the decode stage and the ID/EX pipeline register, in parallel with operand fetch.

## Interface
- `REG_W`, default 5: register-index width.
- `clk_i` input, 1 bit: clock.
- `rst_i` input, 1 bit: reset. Synchronous and active-low.
- `id_valid_i` input, 1 bit: the ID slot holds a real instruction.
- `id_rs_i` input, `REG_W` bits: source register A of the ID instruction.
- `id_rt_i` input, `REG_W` bits: source register B of the ID instruction.
- `id_use_rs_i` input, 1 bit: the ID instruction reads rs.
- `id_use_rt_i` input, 1 bit: the ID instruction reads rt.
- `id_dst_i` input, `REG_W` bits: resolved destination register (rd or rt).
- `id_regwrite_i` input, 1 bit: the ID instruction writes the register file.
- `id_memread_i` input, 1 bit: the ID instruction is a load.
- `flush_i` input, 1 bit: kill the ID instruction (taken branch or jump).
- `fwd_a_sel_o` output, 2 bits: operand-A select for the instruction now in EX.
- `fwd_b_sel_o` output, 2 bits: operand-B select for the instruction now in EX.
- `stall_o` output, 1 bit: hold PC and IF/ID, and insert a bubble into EX.

## Operation
- Select encoding:
  - 00: ID/EX latched register-file value.
  - 01: EX/MEM ALU result.
  - 10: MEM/WB write-back data.
  - 11: retired write-back latch (value written one cycle before WB).
- Tracking shift chain EX→MEM→WB→RET. Each entry holds {valid, dst, regwrite, memread}. Every cycle: RET←WB, WB←MEM, MEM←EX.
- EX entry input:
  - ID fields when `id_valid_i`=1 and neither stall nor flush is active.
  - An invalid bubble otherwise.
- An entry is a producer only if valid=1, regwrite=1 and dst≠0. Register 0 never forwards.
- Select computation, per source operand (rs→A, rt→B), evaluated on the ID instruction at the cycle it advances:
  - Match against current EX entry → 01.
  - Else match against current MEM entry → 10.
  - Else match against current WB entry → 11.
  - Else → 00.
- Nearest producer wins. An unused operand (`id_use_*`=0) gets 00. The result is registered into the select outputs together with the EX-entry load.
- Load-use: `stall_o`=1 when all of the following hold:
  - `id_valid_i`=1;
  - the EX entry is a producer with memread=1;
  - its dst equals a used source of the ID instruction.
- During a stall:
  - The tracking chain still shifts.
  - The EX entry takes a bubble.
  - The selects load 00.
  - Next cycle, the same ID instruction re-evaluates and sees the load in MEM, giving select 10.
- Flush: `flush_i`=1 forces a bubble into EX, forces selects to 00 and masks `stall_o` to 0. Flush wins over stall.

## Timing
- Reset (`rst_i`=0 at a clk_i edge): all entries invalid, both selects 00. `stall_o` evaluates 0 because no entry is valid.
- Selects: registered, one-cycle latency. Valid for the whole cycle the consumer instruction is in EX.
- `stall_o`: purely combinational from ID inputs and the EX entry, with zero latency. It must settle before the same edge that would advance ID.
- A load followed directly by a dependent instruction costs exactly one bubble cycle.
- Reset asserted mid-stall clears the stall condition in the following cycle. No partial state survives reset.
- When rs and rt name the same register, both selects take the same value.

## Structure
- Shared package `cpu_pkg`:
  - `FWD_REGF`=2'b00, `FWD_EXMEM`=2'b01, `FWD_MEMWB`=2'b10, `FWD_RET`=2'b11;
  - tracking-entry field widths.
- Sub-module `fwd_cmp`: compares one source index against three entries and returns a 2-bit select by priority. It is instantiated twice (A, B).
- The top module holds the tracking chain, stall and flush logic, and the select registers.

## Test plan
- No dependency: `add r3,r1,r2` then `sub r6,r4,r5` -> both selects 00, `stall_o`=0.
- Back-to-back ALU dependency: `add r3,..` then `or r7,r3,r3` -> A=01 and B=01 in the consumer's EX cycle.
- Distance 2 and 3: producer r8, one or two unrelated instructions, then consumer reading r8 -> 10 at distance 2, 11 at distance 3. With two producers of r8 at distances 1 and 2 -> 01 (nearest wins).
- Load-use: `lw r9` then `add r10,r9,r1` -> `stall_o`=1 for exactly one cycle, EX bubble, then A=10.
- Writes to r0, then a consumer reading r0 -> 00. A load-use condition with `flush_i`=1 -> `stall_o`=0, EX bubble.
- `rst_i`=0 during a pending load-use -> next cycle selects 00, `stall_o`=0, chain empty.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the operand-forwarding control path.
package cpu_pkg;

  // ALU operand mux select encoding.
  typedef enum logic [1:0] {
    FWD_REGF  = 2'b00,  // ID/EX latched register-file value
    FWD_EXMEM = 2'b01,  // EX/MEM ALU result
    FWD_MEMWB = 2'b10,  // MEM/WB write-back data
    FWD_RET   = 2'b11   // retired write-back latch
  } fwd_sel_e;

  localparam int SEL_W      = 2;
  localparam int REG_W_DEF  = 5;
  // Flag bits carried by each tracking entry besides dst: valid, regwrite, memread.
  localparam int ENT_FLAG_W = 3;

endpackage

// File: rtl/fwd_cmp.sv
// Priority compare of one source register against the EX, MEM and WB entries.
module fwd_cmp
  import cpu_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] src_i,
  input  logic             use_i,
  input  logic             ex_prod_i,
  input  logic [REG_W-1:0] ex_dst_i,
  input  logic             mem_prod_i,
  input  logic [REG_W-1:0] mem_dst_i,
  input  logic             wb_prod_i,
  input  logic [REG_W-1:0] wb_dst_i,
  output logic [SEL_W-1:0] sel_o
);

  // Nearest producer wins; an unused operand always reads the register file.
  always_comb begin
    sel_o = FWD_REGF;
    if (use_i) begin
      if (ex_prod_i && (ex_dst_i == src_i))        sel_o = FWD_EXMEM;
      else if (mem_prod_i && (mem_dst_i == src_i)) sel_o = FWD_MEMWB;
      else if (wb_prod_i && (wb_dst_i == src_i))   sel_o = FWD_RET;
    end
  end

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding select generation and load-use stall detection for a 5-stage CPU.
module forward_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_use_rs_i,
  input  logic             id_use_rt_i,
  input  logic [REG_W-1:0] id_dst_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             flush_i,
  output logic [SEL_W-1:0] fwd_a_sel_o,
  output logic [SEL_W-1:0] fwd_b_sel_o,
  output logic             stall_o
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic             regwrite;
    logic             memread;
  } ent_t;

  ent_t ex_q, mem_q, wb_q, ret_q;
  ent_t ex_d;

  logic             ex_prod, mem_prod, wb_prod;
  logic             load_hit, stall, advance;
  logic [SEL_W-1:0] cmp_a, cmp_b;
  logic [SEL_W-1:0] sel_a_d, sel_b_d, sel_a_q, sel_b_q;

  // Only valid, register-writing entries with a non-zero destination can forward.
  function automatic logic is_prod(ent_t e);
    return e.valid && e.regwrite && (e.dst != '0);
  endfunction

  // Producer qualification of the live entries.
  always_comb begin
    ex_prod  = is_prod(ex_q);
    mem_prod = is_prod(mem_q);
    wb_prod  = is_prod(wb_q);
  end

  fwd_cmp #(.REG_W(REG_W)) u_cmp_a (
    .src_i      (id_rs_i),
    .use_i      (id_use_rs_i),
    .ex_prod_i  (ex_prod),
    .ex_dst_i   (ex_q.dst),
    .mem_prod_i (mem_prod),
    .mem_dst_i  (mem_q.dst),
    .wb_prod_i  (wb_prod),
    .wb_dst_i   (wb_q.dst),
    .sel_o      (cmp_a)
  );

  fwd_cmp #(.REG_W(REG_W)) u_cmp_b (
    .src_i      (id_rt_i),
    .use_i      (id_use_rt_i),
    .ex_prod_i  (ex_prod),
    .ex_dst_i   (ex_q.dst),
    .mem_prod_i (mem_prod),
    .mem_dst_i  (mem_q.dst),
    .wb_prod_i  (wb_prod),
    .wb_dst_i   (wb_q.dst),
    .sel_o      (cmp_b)
  );

  // Load-use detection, flush masking and next-state for the EX entry and selects.
  always_comb begin
    load_hit = ex_prod && ex_q.memread &&
               ((id_use_rs_i && (id_rs_i == ex_q.dst)) ||
                (id_use_rt_i && (id_rt_i == ex_q.dst)));
    stall    = id_valid_i && load_hit && !flush_i;
    advance  = id_valid_i && !stall && !flush_i;
    ex_d     = '0;
    sel_a_d  = FWD_REGF;
    sel_b_d  = FWD_REGF;
    if (advance) begin
      ex_d.valid    = 1'b1;
      ex_d.dst      = id_dst_i;
      ex_d.regwrite = id_regwrite_i;
      ex_d.memread  = id_memread_i;
      sel_a_d       = cmp_a;
      sel_b_d       = cmp_b;
    end
  end

  // Tracking chain shifts every cycle; selects are registered alongside the EX entry.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      ret_q   <= '0;
      sel_a_q <= FWD_REGF;
      sel_b_q <= FWD_REGF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      ret_q   <= wb_q;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  // Bubbles are all-zero entries; that invariant must hold down to the retired slot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      assert (ret_q.valid || (ret_q == '0));
    end
  end

  assign stall_o     = stall;
  assign fwd_a_sel_o = sel_a_q;
  assign fwd_b_sel_o = sel_b_q;

endmodule

// File: tb/tb_forward_ctrl.sv
// Scoreboard bench for forward_ctrl: directed hazard cases followed by random traffic.
module tb_forward_ctrl;

  localparam int RW = 5;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          id_valid_i = 1'b0;
  logic [RW-1:0] id_rs_i = '0;
  logic [RW-1:0] id_rt_i = '0;
  logic          id_use_rs_i = 1'b0;
  logic          id_use_rt_i = 1'b0;
  logic [RW-1:0] id_dst_i = '0;
  logic          id_regwrite_i = 1'b0;
  logic          id_memread_i = 1'b0;
  logic          flush_i = 1'b0;
  logic [1:0]    fwd_a_sel_o, fwd_b_sel_o;
  logic          stall_o;

  forward_ctrl #(.REG_W(RW)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .id_valid_i    (id_valid_i),
    .id_rs_i       (id_rs_i),
    .id_rt_i       (id_rt_i),
    .id_use_rs_i   (id_use_rs_i),
    .id_use_rt_i   (id_use_rt_i),
    .id_dst_i      (id_dst_i),
    .id_regwrite_i (id_regwrite_i),
    .id_memread_i  (id_memread_i),
    .flush_i       (flush_i),
    .fwd_a_sel_o   (fwd_a_sel_o),
    .fwd_b_sel_o   (fwd_b_sel_o),
    .stall_o       (stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit v;
    int rs, rt;
    bit urs, urt;
    int dst;
    bit rw, mr, fl;
  } ins_t;

  // Instruction that entered EX d+1 cycles ago sits at hist[d] (0=EX, 1=MEM, 2=WB).
  typedef struct {
    bit v;
    int dst;
    bit rw, mr;
  } ment_t;

  ment_t hist[3];

  logic [1:0] q_a[$];
  logic [1:0] q_b[$];
  bit         q_st[$];

  int total = 0;
  int bad   = 0;

  function automatic ins_t mk(bit v, int rs, int rt, bit urs, bit urt,
                              int dst, bit rw, bit mr, bit fl);
    ins_t i;
    i.v = v; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
    i.dst = dst; i.rw = rw; i.mr = mr; i.fl = fl;
    return i;
  endfunction

  function automatic bit prod(ment_t e);
    return e.v && e.rw && (e.dst != 0);
  endfunction

  // Select = 1 + distance of the nearest in-flight writer of src, or 0 if none.
  function automatic logic [1:0] ref_sel(int src, bit u);
    if (!u) return 2'd0;
    for (int d = 0; d < 3; d++)
      if (prod(hist[d]) && (hist[d].dst == src)) return 2'(d + 1);
    return 2'd0;
  endfunction

  // One clock of stimulus: drive at negedge, predict, advance the model.
  task automatic drive_cycle(input ins_t ins, input bit rstv, output bit st);
    bit    adv;
    ment_t e;
    rst_i         = rstv;
    id_valid_i    = ins.v;
    id_rs_i       = RW'(ins.rs);
    id_rt_i       = RW'(ins.rt);
    id_use_rs_i   = ins.urs;
    id_use_rt_i   = ins.urt;
    id_dst_i      = RW'(ins.dst);
    id_regwrite_i = ins.rw;
    id_memread_i  = ins.mr;
    flush_i       = ins.fl;
    #1;
    st = ins.v && !ins.fl && prod(hist[0]) && hist[0].mr &&
         ((ins.urs && ins.rs == hist[0].dst) || (ins.urt && ins.rt == hist[0].dst));
    q_st.push_back(st);
    adv = ins.v && !st && !ins.fl;
    e.v = adv; e.dst = adv ? ins.dst : 0; e.rw = adv && ins.rw; e.mr = adv && ins.mr;
    if (!rstv) begin
      q_a.push_back(2'd0);
      q_b.push_back(2'd0);
      for (int d = 0; d < 3; d++) hist[d] = '{0, 0, 0, 0};
    end else begin
      q_a.push_back(adv ? ref_sel(ins.rs, ins.urs) : 2'd0);
      q_b.push_back(adv ? ref_sel(ins.rt, ins.urt) : 2'd0);
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = e;
    end
    @(negedge clk_i);
  endtask

  // Issue an instruction, re-presenting it while the pipeline holds ID.
  task automatic issue(input ins_t ins, input bit rstv);
    bit st;
    int guard = 0;
    do begin
      drive_cycle(ins, rstv, st);
      guard++;
    end while (st && rstv && guard < 4);
  endtask

  // Select monitor: registered outputs checked just after each active edge.
  always @(posedge clk_i) begin
    logic [1:0] ea, eb;
    #1;
    if (q_a.size() > 0) begin
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      total += 2;
      if (fwd_a_sel_o !== ea) begin
        bad++;
        $display("FAIL sel_a t=%0t got=%b want=%b", $time, fwd_a_sel_o, ea);
      end
      if (fwd_b_sel_o !== eb) begin
        bad++;
        $display("FAIL sel_b t=%0t got=%b want=%b", $time, fwd_b_sel_o, eb);
      end
    end
  end

  // Stall monitor: combinational output checked mid-cycle after inputs settle.
  always @(negedge clk_i) begin
    bit es;
    #3;
    if (q_st.size() > 0) begin
      es = q_st.pop_front();
      total++;
      if (stall_o !== es) begin
        bad++;
        $display("FAIL stall t=%0t got=%b want=%b", $time, stall_o, es);
      end
    end
  end

  initial begin
    ins_t nop, ins;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);

    // Reset state.
    issue(nop, 1'b0);
    issue(nop, 1'b0);

    // No dependency.
    issue(mk(1, 1, 2, 1, 1, 3, 1, 0, 0), 1'b1);   // add r3,r1,r2
    issue(mk(1, 4, 5, 1, 1, 6, 1, 0, 0), 1'b1);   // sub r6,r4,r5
    // Back-to-back ALU dependency, rs==rt.
    issue(mk(1, 1, 2, 1, 1, 3, 1, 0, 0), 1'b1);   // add r3
    issue(mk(1, 3, 3, 1, 1, 7, 1, 0, 0), 1'b1);   // or r7,r3,r3
    // Distance 2.
    issue(mk(1, 1, 2, 1, 1, 8, 1, 0, 0), 1'b1);
    issue(mk(1, 4, 5, 1, 1, 11, 1, 0, 0), 1'b1);
    issue(mk(1, 8, 1, 1, 1, 12, 1, 0, 0), 1'b1);
    // Distance 3.
    issue(mk(1, 1, 2, 1, 1, 8, 1, 0, 0), 1'b1);
    issue(mk(1, 4, 5, 1, 1, 11, 1, 0, 0), 1'b1);
    issue(mk(1, 4, 5, 1, 1, 13, 1, 0, 0), 1'b1);
    issue(mk(1, 2, 8, 1, 1, 12, 1, 0, 0), 1'b1);
    // Two producers of r8: nearest wins.
    issue(mk(1, 1, 2, 1, 1, 8, 1, 0, 0), 1'b1);
    issue(mk(1, 1, 2, 1, 1, 8, 1, 0, 0), 1'b1);
    issue(mk(1, 8, 8, 1, 1, 14, 1, 0, 0), 1'b1);
    // Load-use: one bubble, then MEM/WB forward.
    issue(mk(1, 1, 0, 1, 0, 9, 1, 1, 0), 1'b1);   // lw r9
    issue(mk(1, 9, 1, 1, 1, 10, 1, 0, 0), 1'b1);  // add r10,r9,r1
    // Writes to r0 never forward.
    issue(mk(1, 1, 2, 1, 1, 0, 1, 0, 0), 1'b1);
    issue(mk(1, 0, 0, 1, 1, 15, 1, 0, 0), 1'b1);
    // Unused operand matching a producer.
    issue(mk(1, 1, 2, 1, 1, 3, 1, 0, 0), 1'b1);
    issue(mk(1, 3, 3, 0, 0, 4, 1, 0, 0), 1'b1);
    // Load-use under flush, then the same dependency unflushed.
    issue(mk(1, 1, 0, 1, 0, 9, 1, 1, 0), 1'b1);
    issue(mk(1, 9, 1, 1, 1, 10, 1, 0, 1), 1'b1);
    issue(mk(1, 9, 1, 1, 1, 10, 1, 0, 0), 1'b1);
    // Reset during a pending load-use.
    issue(mk(1, 1, 0, 1, 0, 9, 1, 1, 0), 1'b1);
    issue(mk(1, 1, 9, 1, 1, 10, 1, 0, 0), 1'b0);
    issue(mk(1, 1, 9, 1, 1, 10, 1, 0, 0), 1'b1);

    // Random traffic over a small register set to provoke frequent hazards.
    for (int n = 0; n < 1500; n++) begin
      ins = mk($urandom_range(0, 6) != 0,
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 3), $urandom_range(0, 4) != 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      issue(ins, $urandom_range(0, 49) != 0);
    end

    issue(nop, 1'b1);
    issue(nop, 1'b1);
    @(negedge clk_i);
    @(negedge clk_i);
    if (q_a.size() != 0 || q_st.size() != 0) begin
      bad++;
      $display("FAIL drain sel_left=%0d stall_left=%0d want=0", q_a.size(), q_st.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
